// File: rtl/rca_share_seq.sv
// Serial WIDTH-bit adder built on one shared 2-bit ripple slice. Two requesters are
// arbitrated round-robin and the result is returned over a valid/ready handshake.
module rca_share_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] rsp_sum_o,
  output logic             rsp_carry_o,
  output logic             busy_o
);

  localparam int unsigned NSlice = WIDTH / 2;
  localparam int unsigned IdxW   = (NSlice > 1) ? $clog2(NSlice) : 1;

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              carry_q;
  logic [IdxW-1:0]   idx_q;
  logic              id_q;
  logic              last_q;

  logic              grant_valid;
  logic              grant_id;
  logic [1:0]        a_slice, b_slice;
  logic [2:0]        slice_sum;

  // On contention the requester not served last wins.
  always_comb begin
    grant_valid = req0_valid_i | req1_valid_i;
    grant_id    = (req0_valid_i && req1_valid_i) ? ~last_q : req1_valid_i;
  end

  always_comb begin
    a_slice   = a_q[2*idx_q +: 2];
    b_slice   = b_q[2*idx_q +: 2];
    slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {2'b00, carry_q};
  end

  assign req0_ready_o = (state_q == StIdle) && grant_valid && !grant_id;
  assign req1_ready_o = (state_q == StIdle) && grant_valid && grant_id;
  assign rsp_valid_o  = (state_q == StDone);
  assign busy_o       = (state_q != StIdle);
  assign rsp_id_o     = id_q;
  assign rsp_sum_o    = sum_q;
  assign rsp_carry_o  = carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            a_q     <= grant_id ? req1_a_i : req0_a_i;
            b_q     <= grant_id ? req1_b_i : req0_b_i;
            id_q    <= grant_id;
            carry_q <= 1'b0;
            idx_q   <= '0;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          sum_q[2*idx_q +: 2] <= slice_sum[1:0];
          carry_q             <= slice_sum[2];
          idx_q               <= idx_q + 1'b1;
          if (idx_q == IdxW'(NSlice - 1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (rsp_ready_i) begin
            last_q  <= id_q;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/rca_share_seq.md
# rca_share_seq

Sequencer that shares a single 2-bit ripple-carry adder slice between two requesters and uses it to add WIDTH-bit operands serially, 2 bits per cycle. It sits between two operand producers and one result consumer. It arbitrates round-robin, captures operands, and walks the slice from LSBs to MSBs with a registered inter-slice carry. It returns the sum, the carry-out and the winner's ID over a valid/ready handshake.

## Interface
- WIDTH, 8, operand/sum width in bits; must be even and ≥2. Slice count N = WIDTH/2.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has operands.
- req0_ready  output  1  requester 0 operands accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand a.
- req0_b  input  WIDTH  requester 0 operand b.
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  1  requester that owns the result (0/1).
- rsp_sum  output  WIDTH  a + b, low WIDTH bits.
- rsp_carry  output  1  carry-out of the MSB slice.
- busy  output  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, ADD, DONE.
- IDLE:
  - Grant: if exactly one valid, that requester wins. If both are valid, the requester not served last wins. The last-served pointer resets to 1, so req0 wins the first contention.
  - reqX_ready = (state==IDLE) && grant==X; it is combinational and at most one is high.
  - On handshake: capture a, b and ID; clear the carry register to 0; set idx=0; go to ADD.
- ADD, one slice per cycle:
  - {c, s} = a[2idx+1:2idx] + b[2idx+1:2idx] + carry_reg.
  - Write s to sum[2idx+1:2idx]; carry_reg ← c; idx++.
  - After slice N−1, go to DONE.
- DONE:
  - rsp_valid=1; rsp_sum, rsp_carry and rsp_id come from registers and stay stable until accepted.
  - On rsp_valid && rsp_ready: update the last-served pointer to rsp_id and go to IDLE.
  - No new request is accepted in DONE.
- Operand inputs are sampled only at the accept edge. Changes during ADD or DONE are ignored.
- A requester dropping valid before ready is a protocol violation; behaviour is unspecified.
- Arithmetic is modulo 2^WIDTH in rsp_sum, and rsp_carry holds bit WIDTH. The idx counter width is clog2(N), with a minimum of 1.

## Timing
- Reset, asynchronous: state=IDLE, carry_reg=0, idx=0, sum reg=0, id reg=0, pointer=1.
  - Outputs under reset: rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, busy=0.
  - reqX_ready is combinational and may be high in IDLE as soon as reset is released and reqX_valid is high.
- Latency: accept edge at cycle T; ADD occupies cycles T+1..T+N; rsp_valid rises at cycle T+N+1.
- Throughput with rsp_ready tied high: one operation per N+2 cycles (the DONE cycle plus the IDLE accept cycle).
- Reset mid-operation (ADD or DONE): the operation is dropped, no response is produced, and all registers return to reset values.
- rsp_ready held low: the block stays in DONE indefinitely with outputs frozen; both reqX_ready stay 0.
- A request arriving during ADD or DONE waits. It is arbitrated in the next IDLE cycle using the updated pointer.

## Test plan
- WIDTH=8, req0: a=0x5A, b=0x3C, rsp_ready=1 → req0_ready high for 1 cycle; 4 ADD cycles; then rsp_valid with rsp_sum=0x96, rsp_carry=0, rsp_id=0; busy low again 1 cycle later.
- WIDTH=8, req1: a=0xFF, b=0x01 → carry ripples through all 4 slices; rsp_sum=0x00, rsp_carry=1, rsp_id=1.
- After reset, both valid and held (req0: 0x10+0x20, req1: 0x01+0x02):
  - Order: req0 served first (0x30, id 0), then req1 (0x03, id 1).
  - Re-present both with new operands: req0 wins again, since last served was 1.
- Backpressure: rsp_ready=0 for 5 cycles in DONE with req1_valid=1 → rsp outputs frozen, req1_ready stays 0; after rsp_ready=1, req1 is accepted in the following IDLE cycle.
- Reset mid-ADD: assert rst_n=0 during the 2nd ADD cycle → outputs go to reset values immediately; no rsp_valid appears after release unless a new request is made.
- WIDTH=2: a=2'b01, b=2'b11 → 1 ADD cycle; rsp_sum=2'b00, rsp_carry=1; rsp_valid two cycles after the accept edge.
